// File: rtl/ffmul_pkg.sv
// Shared types and constants for the GF(2^m) multiplier scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ffmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    localparam int FF_WIDTH = 409;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int req_id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/ffmul_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr, modulo NREQ.
// Latency: grant is combinational; ptr moves on the accept edge.
// Backpressure: grant holds until accept; ptr only advances on accept.
module rr_arbiter
    import ffmul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = req_id_w(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_vld
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // The winner drops to lowest priority once it has been served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept && grant_vld) begin
            ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ffmul_sched.sv
// Shares one GF(2^m) multiplier between NREQ requesters with round-robin issue and a watchdog.
// Latency: response valid on the cycle the multiplier's done pulse is sampled (or TIMEOUT_CYC cycles after issue).
// Backpressure: one operation in flight; no request is accepted until the owner takes its response.
module ffmul_sched
    import ffmul_pkg::*;
#(
    parameter int WIDTH       = FF_WIDTH,
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    input  logic [WIDTH-2:0]      poly_i,
    output logic [NREQ-1:0]       resp_valid_o,
    input  logic [NREQ-1:0]       resp_ready_i,
    output logic [WIDTH-1:0]      resp_data_o,
    output logic                  resp_err_o,
    output logic [WIDTH-1:0]      mul_a_o,
    output logic [WIDTH-1:0]      mul_b_o,
    output logic [WIDTH-2:0]      mul_poly_o,
    output logic                  mul_en_o,
    input  logic                  mul_done_i,
    input  logic [WIDTH-1:0]      mul_result_i,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      op_cnt_o
);

    localparam int IDW = req_id_w(NREQ);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    sched_state_e   state, state_nx;
    logic [IDW-1:0] owner;
    logic [TW-1:0]  to_cnt;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_vld;

    logic accept;
    logic done_hit;
    logic expired;
    logic resp_hs;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid_i),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        done_hit     = 1'b0;
        expired      = 1'b0;
        resp_hs      = 1'b0;
        req_ready_o  = '0;
        resp_valid_o = '0;
        case (state)
            IDLE: begin
                req_ready_o = grant;
                accept      = grant_vld;
                if (grant_vld) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                // A done pulse on the expiry cycle still delivers the product.
                done_hit = mul_done_i;
                expired  = !mul_done_i && (to_cnt == TW'(TIMEOUT_CYC - 1));
                if (done_hit || expired) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                resp_valid_o[owner] = 1'b1;
                resp_hs             = resp_ready_i[owner];
                if (resp_hs) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Nothing may be handed over on the reset edge: it would be lost silently.
        if (rst) begin
            req_ready_o  = '0;
            resp_valid_o = '0;
            accept       = 1'b0;
            resp_hs      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= '0;
            to_cnt      <= '0;
            mul_a_o     <= '0;
            mul_b_o     <= '0;
            mul_poly_o  <= '0;
            mul_en_o    <= 1'b0;
            resp_data_o <= '0;
            resp_err_o  <= 1'b0;
            op_cnt_o    <= '0;
        end else begin
            if (accept) begin
                mul_a_o    <= req_a_i[grant_idx*WIDTH +: WIDTH];
                mul_b_o    <= req_b_i[grant_idx*WIDTH +: WIDTH];
                mul_poly_o <= poly_i;
                owner      <= grant_idx;
                mul_en_o   <= 1'b1;
                to_cnt     <= '0;
            end
            if (state == BUSY) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (done_hit) begin
                resp_data_o <= mul_result_i;
                resp_err_o  <= 1'b0;
                mul_en_o    <= 1'b0;
            end else if (expired) begin
                resp_data_o <= '0;
                resp_err_o  <= 1'b1;
                mul_en_o    <= 1'b0;
            end
            if (resp_hs) begin
                op_cnt_o <= op_cnt_o + 1'b1;
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: doc/ffmul_sched.md
Name: ffmul_sched

Overview:
- Shares one GF(2^m) field multiplier datapath between NREQ requesters, e.g. the point-add and point-double engines and a CSR-driven path.
- Round-robin arbitration over valid/ready request channels.
- Drives the multiplier's operands, polynomial and enable; watches its completion pulse.
- Returns the product to the owning requester on a per-requester response channel, with a watchdog timeout.

Parameters:
- WIDTH, 409, field element width in bits; matches the multiplier.
- NREQ, 4, number of requesters; valid range 2..8.
- TIMEOUT_CYC, 255, max cycles in BUSY before the operation is aborted; must be > multiplier latency.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  NREQ  per-requester request valid
- req_ready_o  out  NREQ  per-requester request accept; at most one bit set
- req_a_i  in  NREQ*WIDTH  operand A; requester k occupies bits [k*WIDTH +: WIDTH]
- req_b_i  in  NREQ*WIDTH  operand B; same packing
- poly_i  in  WIDTH-1  reduction polynomial, low terms; quasi-static
- resp_valid_o  out  NREQ  one-hot response valid to the owner
- resp_ready_i  in  NREQ  per-requester response accept
- resp_data_o  out  WIDTH  product; shared bus, qualified by resp_valid_o
- resp_err_o  out  1  response is a timeout abort; resp_data_o is 0
- mul_a_o  out  WIDTH  multiplier operand A
- mul_b_o  out  WIDTH  multiplier operand B
- mul_poly_o  out  WIDTH-1  multiplier polynomial
- mul_en_o  out  1  multiplier enable; held high for the whole operation
- mul_done_i  in  1  multiplier completion, single-cycle pulse
- mul_result_i  in  WIDTH  multiplier result; valid in the mul_done_i cycle
- busy_o  out  1  state != IDLE
- op_cnt_o  out  CNT_W  completed operations, including aborts; wraps

Behaviour:
Reset (rst=1 at an edge):
- State IDLE; RR pointer=0.
- All outputs 0: mul_*, resp_*, busy_o, op_cnt_o.
- rst mid-operation aborts silently. No response is issued; mul_en_o drops the next cycle.

FSM states: IDLE, BUSY, RESP.

IDLE:
- Combinational grant: the first set req_valid_i bit searching from ptr upward, modulo NREQ.
- req_ready_o is one-hot to the winner, and only in IDLE.
- On the handshake edge:
  - Latch that requester's operands into mul_a_o/mul_b_o, and poly_i into mul_poly_o.
  - Record owner index; ptr <= (owner+1) mod NREQ.
  - Set mul_en_o=1, clear the timeout counter, go BUSY.
- No valid request: stay in IDLE; outputs hold.

BUSY:
- mul_en_o=1; operands are stable for the whole state.
- Timeout counter increments each cycle.
- mul_done_i=1: latch mul_result_i into resp_data_o, resp_err_o=0, mul_en_o<=0, go RESP.
- Counter reaches TIMEOUT_CYC without done: resp_data_o=0, resp_err_o=1, mul_en_o<=0, go RESP.
- Done and expiry in the same cycle: done wins.

RESP:
- resp_valid_o[owner]=1; mul_en_o=0. Dwell is at least 1 cycle, which guarantees the enable low gap between operations.
- resp_ready_i[owner]=1: op_cnt_o++, clear resp_valid_o, go IDLE.
- Ready bits of non-owners are ignored.
- A new grant is possible in the cycle after the return to IDLE. Back-to-back issue-to-issue gap is 2 cycles plus the multiplier latency.

General rules:
- mul_done_i outside BUSY is ignored.
- poly_i changes take effect at the next grant only.
- A requester that drops req_valid_i without a handshake is legal; arbitration re-evaluates every IDLE cycle.
- op_cnt_o wraps from 2^CNT_W-1 to 0.
- Latency: from the req handshake edge to resp_valid_o high = multiplier latency + 1 cycle.

Decomposition:
- Package ffmul_pkg holds:
  - the state enum sched_state_e {IDLE, BUSY, RESP};
  - the default field width constant;
  - a requester-ID width function clog2(NREQ).
- One sub-module, rr_arbiter (NREQ): comb one-hot grant from req and ptr, plus the registered ptr update on an accept strobe.

Test Plan:
1. Single request: req0 with a=1, b=x (any value) -> mul_en_o high the next cycle; on mul_done_i with result R, resp_valid_o=0001 and resp_data_o=R; op_cnt_o=1 after the resp handshake.
2. Fairness: all four valid continuously, done model at 86 cycles -> grant order 0,1,2,3,0,1; no requester served twice before another pending one.
3. Backpressure: resp_ready_i low for 10 cycles -> resp_valid_o and resp_data_o stable; req_ready_o all 0; mul_en_o 0 throughout.
4. Timeout: done model silent, TIMEOUT_CYC=20 -> RESP is entered 20 cycles after BUSY entry with resp_err_o=1 and resp_data_o=0; the next request is served normally.
5. Done coinciding with expiry -> resp_err_o=0 and the result is delivered; a spurious mul_done_i in IDLE produces no response.
6. rst asserted mid-BUSY -> all outputs 0 next cycle, ptr=0, no resp_valid_o; the subsequent request to req2 completes normally.
